// File: rtl/collision_pkg.sv
// Shared types and constants for the parallel collision search block.
package collision_pkg;

    localparam int DIGEST_W  = 32;
    localparam int MESSAGE_W = 512;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_ABORT  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic int clog2(input int value);
        int width_v;
        width_v = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                width_v = i + 1;
            end
        end
        return width_v;
    endfunction

endpackage

// File: rtl/lane_priority_picker.sv
// Lowest-index-wins selector over the per-lane done requests.
module lane_priority_picker #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 2
) (
    input  logic [NUM_LANES-1:0] req,
    output logic                 valid,
    output logic [LANE_W-1:0]    index
);

    // Scan from the top so the lowest set bit is the last one written
    always_comb begin
        valid = |req;
        index = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = LANE_W'(i);
            end else begin
                index = index;
            end
        end
    end

endmodule

// File: rtl/collision_scheduler.sv
// Fans one collision search out over NUM_LANES searchers split by counter residue,
// stops every lane on the first hit, timeout or host abort.
module collision_scheduler
    import collision_pkg::*;
#(
    parameter int NUM_LANES    = 4,
    parameter int LANE_W       = (clog2(NUM_LANES) < 1) ? 1 : clog2(NUM_LANES),
    parameter int ABORT_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_start,
    input  logic                          cmd_abort,
    input  logic [4:0]                    cmd_target,
    input  logic [MESSAGE_W-1:0]          cmd_message,
    input  logic [DIGEST_W-1:0]           cmd_base,
    input  logic [DIGEST_W-1:0]           cmd_max_digests,
    output logic                          busy,
    output logic                          done,
    output logic                          found,
    output logic [DIGEST_W-1:0]           result,
    output logic [LANE_W-1:0]             winner_lane,
    output logic [DIGEST_W-1:0]           total_digests,
    output logic [NUM_LANES-1:0]          s_start,
    output logic [NUM_LANES-1:0]          s_reset,
    output logic [4:0]                    s_target,
    output logic [MESSAGE_W-1:0]          s_message,
    output logic [DIGEST_W*NUM_LANES-1:0] s_counter,
    output logic [DIGEST_W-1:0]           s_increment,
    input  logic [NUM_LANES-1:0]          s_done,
    input  logic [DIGEST_W*NUM_LANES-1:0] s_result,
    input  logic [DIGEST_W*NUM_LANES-1:0] s_digests
);

    // Four guard bits cover the carry out of summing up to sixteen lanes
    localparam int SUM_W   = DIGEST_W + 4;
    localparam int ABORT_W = (clog2(ABORT_CYCLES) < 1) ? 1 : clog2(ABORT_CYCLES);

    state_t                state_r;
    state_t                state_next_s;
    logic [ABORT_W-1:0]    abort_cnt_r;
    logic [DIGEST_W-1:0]   max_digests_r;
    logic [SUM_W-1:0]      digest_sum_s;
    logic [DIGEST_W-1:0]   digest_sat_s;
    logic                  pick_valid_s;
    logic [LANE_W-1:0]     pick_index_s;
    logic                  budget_hit_s;

    assign s_increment  = DIGEST_W'(NUM_LANES);
    assign budget_hit_s = (max_digests_r != '0) && (total_digests >= max_digests_r);

    lane_priority_picker #(
        .NUM_LANES (NUM_LANES),
        .LANE_W    (LANE_W)
    ) u_picker (
        .req   (s_done),
        .valid (pick_valid_s),
        .index (pick_index_s)
    );

    // Saturating sum of the lane digest counters
    always_comb begin
        digest_sum_s = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            digest_sum_s = digest_sum_s + SUM_W'(s_digests[DIGEST_W*i +: DIGEST_W]);
        end
        if (digest_sum_s[SUM_W-1:DIGEST_W] != '0) begin
            digest_sat_s = '1;
        end else begin
            digest_sat_s = digest_sum_s[DIGEST_W-1:0];
        end
    end

    // Next-state logic; a lane hit outranks abort and timeout in RUN
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_start) begin
                    state_next_s = ST_LAUNCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LAUNCH: state_next_s = ST_RUN;
            ST_RUN: begin
                if (pick_valid_s || cmd_abort || budget_hit_s) begin
                    state_next_s = ST_ABORT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_ABORT: begin
                if (abort_cnt_r == '0) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ABORT;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Control outputs are decoded from the next state so they line up with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            s_start     <= '0;
            s_reset     <= '1;
            abort_cnt_r <= '0;
        end else begin
            busy    <= (state_next_s != ST_IDLE);
            done    <= (state_next_s == ST_DONE);
            s_start <= {NUM_LANES{state_next_s == ST_LAUNCH}};
            s_reset <= {NUM_LANES{state_next_s == ST_ABORT}};
            if (state_r != ST_ABORT) begin
                abort_cnt_r <= ABORT_W'(ABORT_CYCLES - 1);
            end else if (abort_cnt_r != '0) begin
                abort_cnt_r <= abort_cnt_r - ABORT_W'(1);
            end
        end
    end

    // Command latch, result capture and digest total
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            found         <= 1'b0;
            result        <= '0;
            winner_lane   <= '0;
            total_digests <= '0;
            max_digests_r <= '0;
            s_target      <= '0;
            s_message     <= '0;
            s_counter     <= '0;
        end else if ((state_r == ST_IDLE) && cmd_start) begin
            found         <= 1'b0;
            result        <= '0;
            winner_lane   <= '0;
            total_digests <= '0;
            max_digests_r <= cmd_max_digests;
            s_target      <= cmd_target;
            s_message     <= cmd_message;
            for (int i = 0; i < NUM_LANES; i++) begin
                s_counter[DIGEST_W*i +: DIGEST_W] <= cmd_base + DIGEST_W'(i);
            end
        end else if (state_r == ST_RUN) begin
            total_digests <= digest_sat_s;
            if (pick_valid_s) begin
                found       <= 1'b1;
                result      <= s_result[DIGEST_W*pick_index_s +: DIGEST_W];
                winner_lane <= pick_index_s;
            end else if (cmd_abort || budget_hit_s) begin
                found <= 1'b0;
            end
        end
    end

endmodule
